// File: rtl/multicycle_main_cu.sv
// rtl/multicycle_main_cu.sv - main control FSM for the multicycle RV32I datapath
module multicycle_main_cu #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic [1:0]         alu_op,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         result_src,
  output logic [1:0]         imm_src,
  output logic               adr_src,
  output logic               ir_write,
  output logic               pc_write,
  output logic               mem_write,
  output logic               reg_write,
  output logic               instr_done,
  output logic               illegal,
  output logic [3:0]         state,
  output logic [COUNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_ILLEGAL  = 4'd15
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  state_t             r_state;
  state_t             w_next;
  logic [COUNT_W-1:0] r_count;
  logic               r_illegal;
  logic               w_pc_update;
  logic               w_branch;
  logic               w_ir_write;
  logic               w_mem_write;
  logic               w_reg_write;
  logic               w_retire;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_count   <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (instr_done)
        r_count <= r_count + COUNT_W'(1);
      if (r_state == S_ILLEGAL)
        r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_next      = r_state;
    alu_op      = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    adr_src     = 1'b0;
    w_pc_update = 1'b0;
    w_branch    = 1'b0;
    w_ir_write  = 1'b0;
    w_mem_write = 1'b0;
    w_reg_write = 1'b0;
    w_retire    = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        alu_src_b   = 2'b10;
        result_src  = 2'b10;
        w_ir_write  = mem_ready;
        w_pc_update = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECUTER;
          OP_I:         w_next = S_EXECUTEI;
          OP_JAL:       w_next = S_JAL;
          OP_BEQ:       w_next = S_BEQ;
          default:      w_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        w_next    = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src  = 2'b01;
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
        w_next      = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        w_mem_write = 1'b1;
        w_retire    = mem_ready;
        if (mem_ready) w_next = S_FETCH;
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        w_next    = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
        w_next      = S_FETCH;
      end
      S_JAL: begin
        alu_src_a   = 2'b01;
        alu_src_b   = 2'b10;
        w_pc_update = 1'b1;
        w_next      = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        w_branch  = 1'b1;
        w_retire  = 1'b1;
        w_next    = S_FETCH;
      end
      default: w_next = S_ILLEGAL;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // Write strobes are squashed while reset is held so an abandoned instruction leaves no trace.
  assign ir_write    = w_ir_write & rst_n;
  assign pc_write    = (w_pc_update | (w_branch & zero)) & rst_n;
  assign mem_write   = w_mem_write & rst_n;
  assign reg_write   = w_reg_write & rst_n;
  assign instr_done  = w_retire & rst_n;
  assign illegal     = r_illegal;
  assign state       = r_state;
  assign instr_count = r_count;

endmodule

// File: tb/tb_multicycle_main_cu.sv
// tb/tb_multicycle_main_cu.sv - scoreboard bench for multicycle_main_cu
module tb_multicycle_main_cu;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = OP_R;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b1;
  logic [1:0]  alu_op, alu_src_a, alu_src_b, result_src, imm_src;
  logic        adr_src, ir_write, pc_write, mem_write, reg_write, instr_done, illegal;
  logic [3:0]  state;
  logic [31:0] instr_count;
  logic [1:0]  w2_alu_op, w2_src_a, w2_src_b, w2_res, w2_imm;
  logic        w2_adr, w2_ir, w2_pc, w2_mw, w2_rw, w2_done, w2_ill;
  logic [3:0]  w2_state;
  logic [1:0]  w2_count;

  multicycle_main_cu dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .imm_src(imm_src), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .mem_write(mem_write),
    .reg_write(reg_write), .instr_done(instr_done), .illegal(illegal),
    .state(state), .instr_count(instr_count)
  );

  multicycle_main_cu #(.COUNT_W(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .alu_op(w2_alu_op), .alu_src_a(w2_src_a), .alu_src_b(w2_src_b),
    .result_src(w2_res), .imm_src(w2_imm), .adr_src(w2_adr),
    .ir_write(w2_ir), .pc_write(w2_pc), .mem_write(w2_mw),
    .reg_write(w2_rw), .instr_done(w2_done), .illegal(w2_ill),
    .state(w2_state), .instr_count(w2_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] st;
    logic       mr;
  } step_t;

  step_t       sb[$];
  int          push_limit;
  int          n_checks = 0;
  int          n_errors = 0;
  int          exp_cnt = 0;
  logic        exp_illegal = 1'b0;
  int          last_cycles;

  wire [15:0] ctrl_vec = {alu_op, alu_src_a, alu_src_b, result_src, imm_src,
                          adr_src, ir_write, pc_write, mem_write, reg_write, instr_done};
  wire [4:0]  wr_vec   = {ir_write, pc_write, mem_write, reg_write, instr_done};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference decode: {alu_op,src_a,src_b,result_src,imm_src,adr,ir,pc,mw,rw,done}
  function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic [6:0] op,
                                           input logic z, input logic mr);
    logic [1:0] op2, a, b, res, imm;
    logic adr, ir, pc, mw, rw, done;
    {op2, a, b, res, adr, ir, pc, mw, rw, done} = '0;
    imm = (op == OP_SW) ? 2'b01 : (op == OP_BEQ) ? 2'b10 : (op == OP_JAL) ? 2'b11 : 2'b00;
    case (st)
      4'd0:  begin b = 2'b10; res = 2'b10; ir = mr; pc = mr; end
      4'd1:  begin a = 2'b01; b = 2'b01; end
      4'd2:  begin a = 2'b10; b = 2'b01; end
      4'd3:  adr = 1'b1;
      4'd4:  begin res = 2'b01; rw = 1'b1; done = 1'b1; end
      4'd5:  begin adr = 1'b1; mw = 1'b1; done = mr; end
      4'd6:  begin a = 2'b10; op2 = 2'b10; end
      4'd7:  begin rw = 1'b1; done = 1'b1; end
      4'd8:  begin a = 2'b10; b = 2'b01; op2 = 2'b10; end
      4'd9:  begin a = 2'b01; b = 2'b10; pc = 1'b1; end
      4'd10: begin a = 2'b10; op2 = 2'b01; pc = z; done = 1'b1; end
      default: ;
    endcase
    return {op2, a, b, res, imm, adr, ir, pc, mw, rw, done};
  endfunction

  task automatic push_step(input logic [3:0] st, input logic mr);
    if (sb.size() < push_limit) sb.push_back('{st: st, mr: mr});
  endtask

  task automatic push_instr(input logic [6:0] op, input int fstall, input int mstall, input int limit);
    push_limit = limit;
    repeat (fstall) push_step(4'd0, 1'b0);
    push_step(4'd0, 1'b1);
    push_step(4'd1, 1'b1);
    case (op)
      OP_LW:  begin push_step(4'd2, 1'b1); repeat (mstall) push_step(4'd3, 1'b0);
                    push_step(4'd3, 1'b1); push_step(4'd4, 1'b1); end
      OP_SW:  begin push_step(4'd2, 1'b1); repeat (mstall) push_step(4'd5, 1'b0);
                    push_step(4'd5, 1'b1); end
      OP_R:   begin push_step(4'd6, 1'b1); push_step(4'd7, 1'b1); end
      OP_I:   begin push_step(4'd8, 1'b1); push_step(4'd7, 1'b1); end
      OP_JAL: begin push_step(4'd9, 1'b1); push_step(4'd7, 1'b1); end
      OP_BEQ: push_step(4'd10, 1'b1);
      default: repeat (10) push_step(4'd15, 1'b1);
    endcase
  endtask

  // Entered and left at posedge+1; one scoreboard entry per clock.
  task automatic drain(input logic [6:0] op, input logic z);
    step_t s;
    logic [15:0] e;
    opcode = op;
    zero = z;
    last_cycles = 0;
    while (sb.size() > 0) begin
      s = sb.pop_front();
      mem_ready = s.mr;
      @(negedge clk);
      e = exp_ctrl(s.st, op, z, s.mr);
      check_eq("state", {28'd0, state}, {28'd0, s.st});
      check_eq("ctrl", {16'd0, ctrl_vec}, {16'd0, e});
      check_eq("illegal", {31'd0, illegal}, {31'd0, exp_illegal});
      @(posedge clk);
      #1;
      if (s.st == 4'd15) exp_illegal = 1'b1;
      if (e[0]) exp_cnt++;
      last_cycles++;
    end
    mem_ready = 1'b1;
    check_eq("count", instr_count, exp_cnt);
    check_eq("count_w2", {30'd0, w2_count}, exp_cnt & 3);
  endtask

  task automatic run(input logic [6:0] op, input logic z, input int fstall, input int mstall);
    push_instr(op, fstall, mstall, 100);
    drain(op, z);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    repeat (n) begin
      @(negedge clk);
      check_eq("rst_writes", {27'd0, wr_vec}, 32'd0);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    exp_cnt = 0;
    exp_illegal = 1'b0;
    check_eq("rst_state", {28'd0, state}, 32'd0);
    check_eq("rst_illegal", {31'd0, illegal}, 32'd0);
    check_eq("rst_count", instr_count, 32'd0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset(2);

    run(OP_R, 1'b0, 0, 0);
    check_eq("r_cycles", last_cycles, 4);
    run(OP_LW, 1'b0, 0, 2);
    check_eq("lw_cycles", last_cycles, 7);
    run(OP_BEQ, 1'b1, 0, 0);
    check_eq("beq_cycles", last_cycles, 3);
    run(OP_BEQ, 1'b0, 0, 0);
    run(OP_SW, 1'b0, 0, 1);
    check_eq("sw_cycles", last_cycles, 5);
    run(OP_I, 1'b0, 1, 0);
    run(OP_JAL, 1'b0, 0, 0);

    run(OP_BAD, 1'b0, 0, 0);
    check_eq("ill_held", {31'd0, illegal}, 32'd1);
    do_reset(1);

    // Reset while the lw sits in MEMADR
    push_instr(OP_LW, 0, 0, 2);
    drain(OP_LW, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("mid_state", {28'd0, state}, 32'd2);
    check_eq("mid_writes", {27'd0, wr_vec}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("mid_rst_state", {28'd0, state}, 32'd0);
    check_eq("mid_rst_count", instr_count, 32'd0);

    run(OP_R, 1'b0, 0, 0);
    run(OP_I, 1'b0, 0, 0);
    run(OP_BEQ, 1'b1, 0, 0);
    check_eq("w2_at3", {30'd0, w2_count}, 32'd3);
    run(OP_JAL, 1'b0, 0, 0);
    check_eq("w2_wrap", {30'd0, w2_count}, 32'd0);
    check_eq("count_4", instr_count, 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
